// File: rtl/weight_load_scheduler.sv
// Column weight loader: streams one tile down a PE column, drains it, then pulses a switch.
// Outputs registered (1-cycle latency); w_ready is high only in LOAD; the switch waits on compute_idle.
module weight_load_scheduler #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int DATA_WIDTH_IN        = 8,
  parameter int INDEX_WIDTH          = $clog2(SYSTOLIC_ARRAY_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_start,
  output logic                            load_busy,
  input  logic                            w_valid,
  output logic                            w_ready,
  input  logic signed [DATA_WIDTH_IN-1:0] w_data,
  input  logic                            compute_idle,
  output logic signed [DATA_WIDTH_IN-1:0] col_weight_out,
  output logic [INDEX_WIDTH-1:0]          col_index_out,
  output logic                            col_accept_w_out,
  output logic                            col_switch_out,
  output logic                            weights_ready
);

  localparam int DCNT_W = $clog2(SYSTOLIC_ARRAY_WIDTH + 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX   = INDEX_WIDTH'(SYSTOLIC_ARRAY_WIDTH - 1);
  localparam logic [DCNT_W-1:0]      DRAIN_INIT = DCNT_W'(SYSTOLIC_ARRAY_WIDTH);
  localparam logic [DCNT_W-1:0]      DRAIN_LAST = DCNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_WAIT_SW,
    S_SWITCH
  } state_t;

  state_t                     state_q, state_d;
  logic [INDEX_WIDTH-1:0]     wcnt_q, wcnt_d;
  logic [DCNT_W-1:0]          dcnt_q, dcnt_d;
  logic signed [DATA_WIDTH_IN-1:0] weight_q, weight_d;
  logic [INDEX_WIDTH-1:0]     index_q, index_d;
  logic                       accept_q, accept_d;
  logic                       switch_q, switch_d;
  logic                       ready_q, ready_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      dcnt_q   <= '0;
      weight_q <= '0;
      index_q  <= '0;
      accept_q <= 1'b0;
      switch_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      dcnt_q   <= dcnt_d;
      weight_q <= weight_d;
      index_q  <= index_d;
      accept_q <= accept_d;
      switch_q <= switch_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    dcnt_d   = dcnt_q;
    weight_d = weight_q;
    index_d  = index_q;
    accept_d = 1'b0;
    switch_d = 1'b0;
    ready_d  = 1'b0;
    w_ready  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          wcnt_d  = '0;
        end
      end
      S_LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          weight_d = w_data;
          index_d  = wcnt_q;
          accept_d = 1'b1;
          if (wcnt_q == LAST_IDX) begin
            state_d = S_DRAIN;
            dcnt_d  = DRAIN_INIT;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      // One cycle per row so the last weight reaches the bottom PE before the switch.
      S_DRAIN: begin
        dcnt_d = dcnt_q - 1'b1;
        if (dcnt_q == DRAIN_LAST) begin
          state_d = S_WAIT_SW;
        end
      end
      S_WAIT_SW: begin
        if (compute_idle) begin
          state_d  = S_SWITCH;
          switch_d = 1'b1;
          ready_d  = 1'b1;
        end
      end
      S_SWITCH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign load_busy        = (state_q != S_IDLE);
  assign col_weight_out   = weight_q;
  assign col_index_out    = index_q;
  assign col_accept_w_out = accept_q;
  assign col_switch_out   = switch_q;
  assign weights_ready    = ready_q;

endmodule

// File: tb/tb_weight_load_scheduler.sv
// Directed bench for weight_load_scheduler with a 4-row column.
module tb_weight_load_scheduler;

  logic              clk;
  logic              rst;
  logic              load_start;
  logic              load_busy;
  logic              w_valid;
  logic              w_ready;
  logic signed [7:0] w_data;
  logic              compute_idle;
  logic signed [7:0] col_weight_out;
  logic [1:0]        col_index_out;
  logic              col_accept_w_out;
  logic              col_switch_out;
  logic              weights_ready;

  int checks;
  int errors;

  weight_load_scheduler #(
    .SYSTOLIC_ARRAY_WIDTH(4),
    .DATA_WIDTH_IN(8),
    .INDEX_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_start(load_start),
    .load_busy(load_busy),
    .w_valid(w_valid),
    .w_ready(w_ready),
    .w_data(w_data),
    .compute_idle(compute_idle),
    .col_weight_out(col_weight_out),
    .col_index_out(col_index_out),
    .col_accept_w_out(col_accept_w_out),
    .col_switch_out(col_switch_out),
    .weights_ready(weights_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic busy, input logic wrdy,
                            input logic acc, input logic sw, input logic rdy);
    chk({tag, "_busy"}, {31'b0, load_busy}, {31'b0, busy});
    chk({tag, "_wrdy"}, {31'b0, w_ready}, {31'b0, wrdy});
    chk({tag, "_acc"}, {31'b0, col_accept_w_out}, {31'b0, acc});
    chk({tag, "_sw"}, {31'b0, col_switch_out}, {31'b0, sw});
    chk({tag, "_rdy"}, {31'b0, weights_ready}, {31'b0, rdy});
  endtask

  task automatic check_all_zero(input string tag);
    check_outs(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_w"}, col_weight_out, 0);
    chk({tag, "_idx"}, {30'b0, col_index_out}, 0);
  endtask

  // Full tile with w_valid held high and compute_idle high; ends on the IDLE cycle after SWITCH.
  task automatic full_tile(input string tag, input logic signed [7:0] a, input logic signed [7:0] b,
                           input logic signed [7:0] c, input logic signed [7:0] d, input bit now);
    logic signed [7:0] v[4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    if (!now) @(negedge clk);
    load_start = 1'b1; w_valid = 1'b1; w_data = a; compute_idle = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check_outs({tag, "_start"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      w_data = v[k];
      @(negedge clk);
      check_outs({tag, "_load"}, 1'b1, (k < 3), 1'b1, 1'b0, 1'b0);
      chk({tag, "_idx"}, {30'b0, col_index_out}, k);
      chk({tag, "_w"}, col_weight_out, v[k]);
    end
    w_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_outs({tag, "_drain"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    check_outs({tag, "_switch"}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_outs({tag, "_done"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic              bub_vld[7];
  logic signed [7:0] bub_dat[7];
  logic              bub_acc[7];
  int                bub_idx[7];
  logic signed [7:0] bub_w[7];

  initial begin
    checks = 0;
    errors = 0;
    bub_vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bub_dat = '{8'sd21, -8'sd22, 8'sd23, -8'sd24, 8'sd25, -8'sd26, 8'sd27};
    bub_acc = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bub_idx = '{0, 0, 0, 1, 2, 2, 3};
    bub_w   = '{8'sd21, 8'sd21, 8'sd21, -8'sd24, 8'sd25, 8'sd25, 8'sd27};

    // Reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_start   = 1'($urandom);
      w_valid      = 1'($urandom);
      w_data       = 8'($urandom);
      compute_idle = 1'($urandom);
      @(negedge clk);
      check_all_zero("reset");
    end
    load_start = 1'b0; w_valid = 1'b0; w_data = '0; compute_idle = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_all_zero("post_reset");
    end

    // Full load, no bubbles
    full_tile("full", 8'sd3, -8'sd7, 8'sd12, -8'sd128, 1'b0);

    // Bubbles in the weight stream
    @(negedge clk);
    load_start = 1'b1; w_valid = 1'b0; compute_idle = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int j = 0; j < 7; j++) begin
      w_valid = bub_vld[j];
      w_data  = bub_dat[j];
      @(negedge clk);
      chk("bub_acc", {31'b0, col_accept_w_out}, {31'b0, bub_acc[j]});
      chk("bub_idx", {30'b0, col_index_out}, bub_idx[j]);
      chk("bub_w", col_weight_out, bub_w[j]);
    end
    w_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_outs("bub_drain", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    check_outs("bub_switch", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_outs("bub_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Switch gated by compute_idle, with ignored load_start in LOAD and WAIT_SW
    @(negedge clk);
    load_start = 1'b1; w_valid = 1'b1; w_data = 8'sd40; compute_idle = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_data = 8'(40 + k);
      load_start = (k == 1);
      @(negedge clk);
      chk("gate_acc", {31'b0, col_accept_w_out}, 1);
      chk("gate_idx", {30'b0, col_index_out}, k);
      chk("gate_w", col_weight_out, 40 + k);
    end
    load_start = 1'b0; w_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_outs("gate_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      load_start = (i == 10);
    end
    load_start = 1'b0;
    compute_idle = 1'b1;
    @(negedge clk);
    check_outs("gate_switch", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_outs("gate_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back tile started in the IDLE cycle right after SWITCH
    full_tile("b2b", -8'sd1, 8'sd2, -8'sd3, 8'sd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_outs("b2b_quiet", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of a load
    load_start = 1'b1; w_valid = 1'b1; w_data = 8'sd5; compute_idle = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      w_data = 8'(5 + k);
      @(negedge clk);
      chk("mid_idx", {30'b0, col_index_out}, k);
    end
    #2 rst = 1'b0;
    #1 check_all_zero("mid_async");
    @(negedge clk);
    check_all_zero("mid_hold");
    rst = 1'b1; w_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_all_zero("mid_quiet");
    end
    full_tile("fresh", 8'sd9, -8'sd10, 8'sd11, -8'sd12, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
